// File: rtl/distortion_pipe.sv
// Three-stage distortion: pre-gain, waveshaper (hard / asymmetric / fold / rectify),
// post-volume. A clean bypass rides alongside; clipped outputs feed a saturating counter.
module distortion_pipe #(
   parameter int WIDTH     = 16,
   parameter int GAIN_FRAC = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [1:0]              mode,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in,
   input  logic [WIDTH-1:0]        gain,
   input  logic [WIDTH-1:0]        threshold,
   input  logic [WIDTH-1:0]        volume,
   input  logic                    clear,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out,
   output logic                    clip_active,
   output logic [CNT_WIDTH-1:0]    clip_count
);
   localparam int EW  = WIDTH + 2;
   localparam int PW1 = 2*WIDTH + 1;
   localparam int PW3 = EW + WIDTH + 1;

   localparam logic signed [WIDTH-1:0] S_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [EW-1:0]    E_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0]    E_MIN  = {3'b111, {(WIDTH-1){1'b0}}};
   localparam logic signed [PW1-1:0]   P1_MAX = {{(PW1-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW1-1:0]   P1_MIN = {{(PW1-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [PW3-1:0]   P3_MAX = {{(PW3-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW3-1:0]   P3_MIN = {{(PW3-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   // stage 1: pre-gain
   logic                    v1_q, en1_q;
   logic [1:0]              mode1_q;
   logic signed [WIDTH-1:0] raw1_q, x1_q, x1_d;
   logic signed [PW1-1:0]   prod1, shf1;

   always_comb begin
      prod1 = PW1'(in) * PW1'($signed({1'b0, gain}));
      shf1  = prod1 >>> GAIN_FRAC;
      if (shf1 > P1_MAX)      x1_d = S_MAX;
      else if (shf1 < P1_MIN) x1_d = S_MIN;
      else                    x1_d = shf1[WIDTH-1:0];
   end

   // stage 2: waveshaper, evaluated two bits wider so folding never wraps
   logic                    v2_q, en2_q, clip2_q, clip2_d;
   logic signed [WIDTH-1:0] raw2_q;
   logic signed [EW-1:0]    y2_q, y2_d;
   logic signed [EW-1:0]    t_e, xe, hi, lo, shaped, probe;

   always_comb begin
      t_e    = threshold[WIDTH-1] ? E_MAX : EW'(threshold);
      xe     = EW'(x1_q);
      hi     = t_e;
      lo     = -t_e;
      shaped = xe;
      probe  = xe;
      case (mode1_q)
         2'd1: lo = -(t_e >>> 1);
         2'd2: begin
            if (xe > t_e)       shaped = (t_e <<< 1) - xe;
            else if (xe < -t_e) shaped = -(t_e <<< 1) - xe;
         end
         2'd3: begin
            lo     = '0;
            shaped = (xe == E_MIN) ? E_MAX : (xe[EW-1] ? -xe : xe);
            probe  = shaped;
         end
         default: ;
      endcase
      clip2_d = (probe > hi) || (probe < lo);
      if (shaped > hi)      y2_d = hi;
      else if (shaped < lo) y2_d = lo;
      else                  y2_d = shaped;
   end

   // stage 3: post-volume and bypass select
   logic                    out_valid_q, clip_q, clip_d;
   logic signed [WIDTH-1:0] out_q, out_d;
   logic signed [PW3-1:0]   prod3, shf3;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

   always_comb begin
      prod3 = PW3'(y2_q) * PW3'($signed({1'b0, volume}));
      shf3  = prod3 >>> GAIN_FRAC;
      if (shf3 > P3_MAX)      out_d = S_MAX;
      else if (shf3 < P3_MIN) out_d = S_MIN;
      else                    out_d = shf3[WIDTH-1:0];
      clip_d = clip2_q;
      if (!en2_q) begin
         out_d  = raw2_q;
         clip_d = 1'b0;
      end
   end

   // the count moves on the same edge that presents the clipped sample
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (v2_q && en2_q && clip2_q && (cnt_q != {CNT_WIDTH{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q        <= 1'b0;
         en1_q       <= 1'b0;
         mode1_q     <= '0;
         raw1_q      <= '0;
         x1_q        <= '0;
         v2_q        <= 1'b0;
         en2_q       <= 1'b0;
         clip2_q     <= 1'b0;
         raw2_q      <= '0;
         y2_q        <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         clip_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         v1_q        <= in_valid;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         cnt_q       <= cnt_d;
         if (in_valid) begin
            en1_q   <= enable;
            mode1_q <= mode;
            raw1_q  <= in;
            x1_q    <= x1_d;
         end
         if (v1_q) begin
            en2_q   <= en1_q;
            clip2_q <= clip2_d;
            raw2_q  <= raw1_q;
            y2_q    <= y2_d;
         end
         if (v2_q) begin
            out_q  <= out_d;
            clip_q <= clip_d;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out         = out_q;
   assign clip_active = clip_q;
   assign clip_count  = cnt_q;
endmodule

// File: tb/tb_distortion_pipe.sv
// Scoreboarded bench for distortion_pipe: directed cases, boundary thresholds,
// bypass interleaving, random traffic, counter saturation/clear and mid-flight reset.
module tb_distortion_pipe;
   localparam int W = 16;

   typedef struct { logic [W-1:0] o; logic c; int cyc; } exp_t;
   typedef struct {
      bit v; bit en; logic [1:0] md;
      logic [W-1:0] x; logic [W-1:0] g; logic [W-1:0] t; logic [W-1:0] vol;
      bit um; logic [W-1:0] eo; logic ec;
   } stim_t;

   logic clk = 1'b0;
   logic reset, enable, in_valid, clear;
   logic [1:0] mode;
   logic [W-1:0] din, gain, threshold, volume;
   logic out_valid, clip_active;
   logic [W-1:0] dout;
   logic [15:0] clip_count;

   exp_t sb[$];
   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   distortion_pipe #(.WIDTH(16), .GAIN_FRAC(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .in_valid(in_valid),
      .in(din), .gain(gain), .threshold(threshold), .volume(volume), .clear(clear),
      .out_valid(out_valid), .out(dout), .clip_active(clip_active), .clip_count(clip_count)
   );

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic exp_t model(input stim_t s);
      longint x, tl, hi, lo, f, y, o;
      bit c;
      exp_t r;
      r.cyc = 0;
      if (!s.en) begin
         r.o = s.x; r.c = 1'b0;
         return r;
      end
      x  = sat16((longint'($signed(s.x)) * longint'(s.g)) >>> 8);
      tl = (s.t > 16'h7FFF) ? 32767 : longint'(s.t);
      hi = tl; lo = -tl; f = x;
      c  = (x > hi) || (x < lo);
      case (s.md)
         2'd1: begin lo = -(tl / 2); c = (x > hi) || (x < lo); end
         2'd2: begin
            if (x > tl)       f = 2*tl - x;
            else if (x < -tl) f = -2*tl - x;
         end
         2'd3: begin
            f  = (x < 0) ? ((x == -32768) ? 32767 : -x) : x;
            lo = 0;
            c  = f > tl;
         end
         default: ;
      endcase
      y = (f > hi) ? hi : ((f < lo) ? lo : f);
      o = sat16((y * longint'(s.vol)) >>> 8);
      r.o = o[W-1:0];
      r.c = c;
      return r;
   endfunction

   function automatic stim_t mk(input bit v, input bit en, input logic [1:0] md,
                                input logic [W-1:0] x, input logic [W-1:0] g,
                                input logic [W-1:0] t, input logic [W-1:0] vol,
                                input bit um, input logic [W-1:0] eo, input logic ec);
      stim_t s;
      s.v = v; s.en = en; s.md = md; s.x = x; s.g = g; s.t = t; s.vol = vol;
      s.um = um; s.eo = eo; s.ec = ec;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(1'b0, 1'b0, 2'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
   endfunction

   // drives one cycle of stimulus; idle cycles scramble the data inputs
   task automatic apply(input stim_t s);
      exp_t e;
      in_valid = s.v;
      if (s.v) begin
         enable = s.en; mode = s.md; din = s.x; gain = s.g;
         threshold = s.t; volume = s.vol;
         if (s.um) e = model(s);
         else begin e.o = s.eo; e.c = s.ec; end
         e.cyc = cyc;
         sb.push_back(e);
      end else begin
         din = W'($urandom); enable = 1'($urandom); mode = 2'($urandom);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; enable = 1'b1; mode = 2'd0;
      din = '0; gain = 16'h0100; threshold = 16'h1000; volume = 16'h0100;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h, required 0000", dout); end
      n_cmp++; if (clip_active !== 1'b0) begin n_err++; $display("FAIL reset_clip: got %b, required 0", clip_active); end
      n_cmp++; if (clip_count !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h, required 0000", clip_count); end
      $display("reset: out=%h valid=%b clip=%b cnt=%h", dout, out_valid, clip_active, clip_count);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      stim_t st[$];
      exp_t e;
      logic [W-1:0] last_o = '0;
      logic last_c = 1'b0;
      bit seen = 1'b0;
      st.push_back(mk(1, 1, 2'd0, 16'h0800, 16'h0100, 16'h1000, 16'h0100, 0, 16'h0800, 1'b0));
      for (int i = 0; i < 8; i++) st.push_back(idle());
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL basic_extra: out_valid=1 out=%h, required no output", dout);
            end else begin
               e = sb.pop_front();
               if (e.c) exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
               if (dout !== e.o || clip_active !== e.c || cyc != e.cyc + 3) begin
                  n_err++;
                  $display("FAIL basic_out: out=%h clip=%b cyc=%0d, required out=%h clip=%b cyc=%0d", dout, clip_active, cyc, e.o, e.c, e.cyc + 3);
               end else $display("basic: out=%h clip=%b cnt=%0d", dout, clip_active, clip_count);
               n_cmp++;
               if (clip_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL basic_cnt: got %0d, required %0d", clip_count, exp_cnt); end
               last_o = e.o; last_c = e.c; seen = 1'b1;
            end
         end else if (seen) begin
            n_cmp++;
            if (dout !== last_o || clip_active !== last_c) begin
               n_err++; $display("FAIL basic_hold: out=%h clip=%b, required out=%h clip=%b", dout, clip_active, last_o, last_c);
            end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_missing: %0d outputs outstanding, required 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_clip_modes();
      stim_t st[$];
      exp_t e;
      st.push_back(mk(1, 1, 2'd0, 16'h0800, 16'h0400, 16'h1000, 16'h0100, 0, 16'h1000, 1'b1));
      st.push_back(idle());
      st.push_back(mk(1, 1, 2'd0, 16'h8000, 16'h0400, 16'h1000, 16'h0100, 0, 16'hF000, 1'b1));
      st.push_back(mk(1, 1, 2'd1, 16'hF800, 16'h0400, 16'h1000, 16'h0100, 0, 16'hF800, 1'b1));
      st.push_back(mk(1, 1, 2'd1, 16'h0800, 16'h0400, 16'h1000, 16'h0100, 0, 16'h1000, 1'b1));
      st.push_back(mk(1, 1, 2'd2, 16'h1400, 16'h0100, 16'h1000, 16'h0100, 0, 16'h0C00, 1'b1));
      st.push_back(mk(1, 1, 2'd2, 16'hEC00, 16'h0100, 16'h1000, 16'h0100, 0, 16'hF400, 1'b1));
      st.push_back(mk(1, 1, 2'd0, 16'h1000, 16'h0100, 16'h1000, 16'h0100, 0, 16'h1000, 1'b0));
      st.push_back(mk(1, 1, 2'd0, 16'h1001, 16'h0100, 16'h1000, 16'h0100, 0, 16'h1000, 1'b1));
      st.push_back(mk(1, 1, 2'd3, 16'hF000, 16'h0100, 16'h1000, 16'h0100, 0, 16'h1000, 1'b0));
      for (int i = 0; i < 5; i++) st.push_back(idle());
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL clip_extra: out_valid=1 out=%h, required no output", dout);
            end else begin
               e = sb.pop_front();
               if (e.c) exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
               if (dout !== e.o || clip_active !== e.c || cyc != e.cyc + 3) begin
                  n_err++;
                  $display("FAIL clip_out: out=%h clip=%b cyc=%0d, required out=%h clip=%b cyc=%0d", dout, clip_active, cyc, e.o, e.c, e.cyc + 3);
               end else $display("clip_modes: out=%h clip=%b cnt=%0d", dout, clip_active, clip_count);
               n_cmp++;
               if (clip_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL clip_cnt: got %0d, required %0d", clip_count, exp_cnt); end
            end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL clip_missing: %0d outputs outstanding, required 0", sb.size()); end
      sb.delete();
   endtask

   // threshold/volume change only after three idle cycles, so in-flight samples see stable values
   task automatic test_saturation();
      stim_t st[$];
      exp_t e;
      st.push_back(mk(1, 1, 2'd0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 0, 16'h7FFF, 1'b0));
      st.push_back(mk(1, 1, 2'd0, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 0, 16'h8000, 1'b1));
      repeat (3) st.push_back(idle());
      st.push_back(mk(1, 1, 2'd3, 16'h8000, 16'h0100, 16'h1000, 16'h0100, 0, 16'h1000, 1'b1));
      repeat (3) st.push_back(idle());
      st.push_back(mk(1, 1, 2'd0, 16'h0001, 16'h0100, 16'h0000, 16'h0100, 0, 16'h0000, 1'b1));
      st.push_back(mk(1, 1, 2'd0, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 0, 16'h0000, 1'b0));
      st.push_back(mk(1, 1, 2'd3, 16'h8000, 16'h0100, 16'h0000, 16'h0100, 0, 16'h0000, 1'b1));
      repeat (3) st.push_back(idle());
      st.push_back(mk(1, 1, 2'd0, 16'h8000, 16'h0100, 16'hFFFF, 16'h0100, 0, 16'h8001, 1'b1));
      st.push_back(mk(1, 1, 2'd1, 16'h8000, 16'h0100, 16'hFFFF, 16'h0100, 0, 16'hC001, 1'b1));
      repeat (3) st.push_back(idle());
      st.push_back(mk(1, 1, 2'd0, 16'h0800, 16'h0100, 16'h1000, 16'h0200, 0, 16'h1000, 1'b0));
      st.push_back(mk(1, 1, 2'd0, 16'h4000, 16'h0100, 16'h1000, 16'h0200, 0, 16'h2000, 1'b1));
      repeat (5) st.push_back(idle());
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL sat_extra: out_valid=1 out=%h, required no output", dout);
            end else begin
               e = sb.pop_front();
               if (e.c) exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
               if (dout !== e.o || clip_active !== e.c || cyc != e.cyc + 3) begin
                  n_err++;
                  $display("FAIL sat_out: out=%h clip=%b cyc=%0d, required out=%h clip=%b cyc=%0d", dout, clip_active, cyc, e.o, e.c, e.cyc + 3);
               end else $display("saturation: out=%h clip=%b cnt=%0d", dout, clip_active, clip_count);
               n_cmp++;
               if (clip_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL sat_cnt: got %0d, required %0d", clip_count, exp_cnt); end
            end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sat_missing: %0d outputs outstanding, required 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      exp_t e;
      logic [W-1:0] rx, rg;
      st.push_back(mk(1, 0, 2'd0, 16'h1234, 16'h0400, 16'h0C00, 16'h0180, 0, 16'h1234, 1'b0));
      for (int i = 0; i < 8; i++) begin
         rx = W'($urandom); rg = W'($urandom_range(0, 16'h0600));
         st.push_back(mk(1, (i % 2) == 0, 2'($urandom), rx, rg, 16'h0C00, 16'h0180, 1, '0, 1'b0));
      end
      for (int i = 0; i < 40; i++) begin
         rx = W'($urandom); rg = W'($urandom_range(0, 16'h0800));
         if ($urandom_range(0, 3) == 0) st.push_back(idle());
         else st.push_back(mk(1, $urandom_range(0, 4) != 0, 2'($urandom), rx, rg, 16'h0C00, 16'h0180, 1, '0, 1'b0));
      end
      repeat (5) st.push_back(idle());
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL b2b_extra: out_valid=1 out=%h, required no output", dout);
            end else begin
               e = sb.pop_front();
               if (e.c) exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
               if (dout !== e.o || clip_active !== e.c || cyc != e.cyc + 3) begin
                  n_err++;
                  $display("FAIL b2b_out: out=%h clip=%b cyc=%0d, required out=%h clip=%b cyc=%0d", dout, clip_active, cyc, e.o, e.c, e.cyc + 3);
               end else $display("back_to_back: out=%h clip=%b cnt=%0d", dout, clip_active, clip_count);
               n_cmp++;
               if (clip_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL b2b_cnt: got %0d, required %0d", clip_count, exp_cnt); end
            end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_missing: %0d outputs outstanding, required 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_count_saturate();
      enable = 1'b1; mode = 2'd0; din = 16'h0800; gain = 16'h0400;
      threshold = 16'h1000; volume = 16'h0100;
      in_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (clip_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_hold: got %h, required FFFF", clip_count); end
      $display("count_saturate: cnt=%h", clip_count);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1; clear = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (clip_count !== 16'h0000) begin n_err++; $display("FAIL cnt_clear: got %h, required 0000", clip_count); end
      $display("count_clear: cnt=%h clip=%b valid=%b", clip_count, clip_active, out_valid);
      clear = 1'b0; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_flight();
      int c0;
      enable = 1'b1; mode = 2'd0; din = 16'h0800; gain = 16'h0100;
      threshold = 16'h1000; volume = 16'h0100;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1; reset = 1'b1; in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || dout !== 16'h0000 || clip_active !== 1'b0 || clip_count !== 16'h0000) begin
         n_err++;
         $display("FAIL flight_reset: valid=%b out=%h clip=%b cnt=%h, required 0/0000/0/0000", out_valid, dout, clip_active, clip_count);
      end
      $display("reset_flight: valid=%b out=%h cnt=%h", out_valid, dout, clip_count);
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL flight_ghost: out_valid=%b out=%h, required 0", out_valid, dout); end
      end
      din = 16'h0400; in_valid = 1'b1; c0 = cyc;
      @(posedge clk); #1; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== (cyc == c0 + 3)) begin
            n_err++; $display("FAIL flight_first: cyc=%0d out_valid=%b, required %b", cyc, out_valid, cyc == c0 + 3);
         end else if (out_valid === 1'b1) begin
            n_cmp++;
            if (dout !== 16'h0400) begin n_err++; $display("FAIL flight_data: got %h, required 0400", dout); end
            $display("reset_flight_first: out=%h cyc=%0d", dout, cyc);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clip_modes();
      test_saturation();
      test_back_to_back();
      test_count_saturate();
      test_reset_flight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/distortion_pipe.md
DISTORTION_PIPE -- requirements
Module: distortion_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample/control word width in bits, minimum 8.
REQ-002 SHALL have parameter GAIN_FRAC, default 8, meaning fractional bits of gain and volume (unsigned fixed point), less than WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the clip counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 enable  input  1  1 = distortion path, 0 = clean bypass; sampled with each input sample.
REQ-007 mode  input  2  shaping mode, sampled with each input sample: 0 hard, 1 asymmetric, 2 fold, 3 rectify.
REQ-008 in_valid  input  1  in carries a new sample this cycle.
REQ-009 in  input  WIDTH  signed two's-complement sample.
REQ-010 gain  input  WIDTH  unsigned pre-gain; sampled in stage 1.
REQ-011 threshold  input  WIDTH  clip magnitude T; values above 2^(WIDTH-1)-1 clamp to that value; sampled in stage 2.
REQ-012 volume  input  WIDTH  unsigned post-gain; sampled in stage 3.
REQ-013 clear  input  1  synchronous clear of clip_count.
REQ-014 out_valid  output  1  out carries a processed sample.
REQ-015 out  output  WIDTH  signed processed sample.
REQ-016 clip_active  output  1  the sample on out exceeded its clip limit; qualified by out_valid.
REQ-017 clip_count  output  CNT_WIDTH  saturating count of clipped output samples.

Function
REQ-018 SHALL be a 3-stage valid-only pipeline, no backpressure: out_valid asserts exactly 3 cycles after in_valid, one output per input, order preserved.
REQ-019 Bubbles (in_valid=0) SHALL propagate as out_valid=0; out and clip_active hold their last values while out_valid=0.
REQ-020 Stage 1 SHALL compute x = (in * gain) arithmetic-shifted right by GAIN_FRAC, full-precision product, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 Stage 2 SHALL shape x with T: mode 0 y = clamp(x, -T, T); mode 1 positive limit T, negative limit -(T>>1); mode 2 x>T gives 2T-x, x<-T gives -2T-x, result then clamped to [-T,T]; mode 3 y = clamp(|x|, 0, T), with |most negative| = 2^(WIDTH-1)-1.
REQ-022 Stage 2 intermediates SHALL be at least WIDTH+2 bits; no wrap-around anywhere.
REQ-023 clip_active SHALL be 1 iff x was above the positive limit or below the negative limit for that sample (mode 3: |x|>T); T=0 gives y=0 and clip_active=1 for any nonzero x.
REQ-024 Stage 3 SHALL compute out = (y * volume) >> GAIN_FRAC (arithmetic), saturated to WIDTH signed.
REQ-025 enable=0 sample SHALL appear on out unchanged (in delayed 3 cycles), with clip_active=0; enable/mode changes affect only samples entering after the change.
REQ-026 clip_count SHALL increment by 1 on each cycle where out_valid and clip_active are both 1, holding at 2^CNT_WIDTH-1.
REQ-027 clear SHALL set clip_count to 0 on the next edge; clear wins over a simultaneous increment.

Reset
REQ-028 While reset is high: out=0, out_valid=0, clip_active=0, clip_count=0, all stage valids 0, asynchronously.
REQ-029 Samples in flight at reset assertion SHALL be discarded; first output after release is the first sample accepted after release, 3 cycles later.

Verification (WIDTH=16, GAIN_FRAC=8, volume=0x0100, T=0x1000 unless stated)
REQ-030 mode 0, gain=0x0100, in=0x0800 valid one cycle -> out=0x0800, out_valid pulse exactly 3 cycles later, clip_active=0, clip_count unchanged.
REQ-031 mode 0, gain=0x0400, in=0x0800 -> x=0x2000, out=0x1000, clip_active=1, clip_count 0->1; in=0x8000 -> out=0xF000.
REQ-032 mode 1, gain=0x0400, in=0xF800 -> out=0xF800 (-0x0800), clip_active=1; mode 2, gain=0x0100, in=0x1400 -> out=0x0C00, clip_active=1.
REQ-033 gain=0xFFFF, in=0x7FFF, T=0x7FFF, volume=0xFFFF -> out=0x7FFF (both saturations); mode 3, in=0x8000, gain=0x0100 -> out=0x1000.
REQ-034 enable=0, in=0x1234, gain=0x0400 -> out=0x1234, clip_active=0; back-to-back samples alternating enable 1/0 each emerge with correct per-sample path.
REQ-035 reset asserted with 2 samples in flight -> out_valid=0 immediately, no output after release; clip_count forced to 0xFFFF via clipping holds; clear with concurrent clip -> 0.
